shake_128_expand_a_seq: RTL and testbench

- Sequencer for the SHAKE-128 ExpandA stage of Dilithium key generation, signing and verification.
- Walks every matrix entry (i,j), i=0..K-1 (row), j=0..L-1 (column), in row-major order.
- For each entry it drives the index bytes to the combinational SHAKE-128 input formatter and launches the shared Keccak-f[1600] core.
- It hands each 1344-bit rate block to the rejection sampler and issues further squeezes until the sampler reports the polynomial complete.

---
 rtl/shake_128_expand_a_seq.sv | 144 ++++++++++++++
 tb/tb_shake_128_expand_a_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shake_128_expand_a_seq.sv
// Sequencer for the SHAKE-128 ExpandA matrix walk: launches Keccak per (i,j) entry and feeds rate blocks to the sampler.
// Optional macro SHAKE_SQZ_LIMIT_EN caps squeezes per entry at MAX_SQZ (abandons the entry and sets err).
module shake_128_expand_a_seq #(
    parameter int K       = 4,
    parameter int L       = 4,
    parameter int MAX_SQZ = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] i_idx,
    output logic [7:0] j_idx,
    output logic       kc_start,
    output logic       kc_init,
    input  logic       kc_done,
    output logic       blk_valid,
    input  logic       blk_ready,
    input  logic       smp_more,
    input  logic       smp_fin,
    output logic [3:0] sqz_cnt,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, OFFER, DECIDE, NEXT, FIN} state_t;

`ifdef SHAKE_SQZ_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic [7:0] i_next, j_next;
    logic [3:0] sqz_next;
    logic       err_next;
    logic       fin_pend_reg, fin_pend_next;
    logic       more_pend_reg, more_pend_next;
    logic       fin_now, more_now, last_entry, limit_hit;

    // Sampler pulses that land during OFFER are held until DECIDE consumes them.
    assign fin_now    = smp_fin | fin_pend_reg;
    assign more_now   = smp_more | more_pend_reg;
    assign last_entry = (i_idx == 8'(K - 1)) && (j_idx == 8'(L - 1));
    assign limit_hit  = LIMIT_EN && (sqz_cnt == 4'(MAX_SQZ));

    assign busy      = (state_reg != IDLE) && (state_reg != FIN);
    assign done      = (state_reg == FIN);
    assign kc_start  = (state_reg == LAUNCH);
    assign kc_init   = (state_reg == LAUNCH) && (sqz_cnt == 4'd0);
    assign blk_valid = (state_reg == OFFER);

    always_comb begin
        state_next     = state_reg;
        i_next         = i_idx;
        j_next         = j_idx;
        sqz_next       = sqz_cnt;
        err_next       = err;
        fin_pend_next  = fin_pend_reg;
        more_pend_next = more_pend_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = LAUNCH;
                    i_next         = 8'd0;
                    j_next         = 8'd0;
                    sqz_next       = 4'd0;
                    err_next       = 1'b0;
                    fin_pend_next  = 1'b0;
                    more_pend_next = 1'b0;
                end
            end
            LAUNCH: begin
                if (sqz_cnt != 4'hF) sqz_next = sqz_cnt + 4'd1;
                fin_pend_next  = 1'b0;
                more_pend_next = 1'b0;
                state_next     = WAIT;
            end
            WAIT: begin
                if (kc_done) state_next = OFFER;
            end
            OFFER: begin
                fin_pend_next  = fin_pend_reg | smp_fin;
                more_pend_next = more_pend_reg | smp_more;
                if (blk_ready) state_next = DECIDE;
            end
            DECIDE: begin
                fin_pend_next  = 1'b0;
                more_pend_next = 1'b0;
                if (fin_now) begin
                    if (more_now) err_next = 1'b1;
                    state_next = NEXT;
                end else if (more_now) begin
                    if (limit_hit) begin
                        err_next   = 1'b1;
                        state_next = NEXT;
                    end else begin
                        state_next = LAUNCH;
                    end
                end
            end
            NEXT: begin
                sqz_next = 4'd0;
                // Indices hold on the final entry so they never exceed K-1 / L-1.
                if (last_entry) begin
                    state_next = FIN;
                end else begin
                    if (j_idx == 8'(L - 1)) begin
                        j_next = 8'd0;
                        i_next = i_idx + 8'd1;
                    end else begin
                        j_next = j_idx + 8'd1;
                    end
                    state_next = LAUNCH;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kc_done && (state_reg != WAIT)) err_next = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            i_idx         <= 8'd0;
            j_idx         <= 8'd0;
            sqz_cnt       <= 4'd0;
            err           <= 1'b0;
            fin_pend_reg  <= 1'b0;
            more_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            i_idx         <= i_next;
            j_idx         <= j_next;
            sqz_cnt       <= sqz_next;
            err           <= err_next;
            fin_pend_reg  <= fin_pend_next;
            more_pend_reg <= more_pend_next;
        end
    end

endmodule

// File: tb/tb_shake_128_expand_a_seq.sv
// Scoreboard bench: expected launch list built from a per-entry squeeze plan; a monitor pops on every kc_start.
module tb_shake_128_expand_a_seq;
    localparam int K = 4, L = 4, MAX_SQZ = 2, N = K * L;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       kc_done = 1'b0, blk_ready = 1'b0, smp_more = 1'b0, smp_fin = 1'b0;
    logic       busy, done, kc_start, kc_init, blk_valid, err;
    logic [7:0] i_idx, j_idx;
    logic [3:0] sqz_cnt;

    shake_128_expand_a_seq #(.K(K), .L(L), .MAX_SQZ(MAX_SQZ)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .i_idx(i_idx), .j_idx(j_idx), .kc_start(kc_start), .kc_init(kc_init),
        .kc_done(kc_done), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .smp_more(smp_more), .smp_fin(smp_fin), .sqz_cnt(sqz_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] j;
        logic       init;
        logic [3:0] cnt;
    } launch_t;

    launch_t exp_q[$];
    launch_t last_l;
    int  total = 0, bad = 0;
    int  extra[N];
    int  stall_entry = -1, both_entry = -1;
    bit  all_more = 1'b0;
    int  done_seen = 0, launches = 0;
    int  resp_ent = 0, resp_blocks = 0;
    int  kc_wait = 0, stall = 0;
    bit  in_offer = 1'b0, early = 1'b0, prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: entry e=(e/L, e%L) gets 1+extra[e] launches, the first with init=1.
    task automatic load_expect();
        launch_t t;
        int n;
        exp_q.delete();
        for (int e = 0; e < N; e++) begin
            n = all_more ? MAX_SQZ : extra[e] + 1;
            for (int k = 0; k < n; k++) begin
                t.i    = 8'(e / L);
                t.j    = 8'(e % L);
                t.init = (k == 0);
                t.cnt  = (k > 15) ? 4'hF : 4'(k);
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic send_pulse();
        resp_blocks++;
        if (all_more) begin
            smp_more = 1'b1;
        end else if (resp_ent >= N || resp_blocks > extra[resp_ent]) begin
            smp_fin = 1'b1;
            if (resp_ent == both_entry) smp_more = 1'b1;
            resp_ent++;
            resp_blocks = 0;
        end else begin
            smp_more = 1'b1;
        end
    endtask

    // Keccak core and sampler responder.
    initial begin
        forever begin
            @(posedge clk); #1;
            kc_done  = 1'b0;
            smp_more = 1'b0;
            smp_fin  = 1'b0;
            if (rst) begin
                kc_wait = 0; in_offer = 1'b0; blk_ready = 1'b0;
                resp_ent = 0; resp_blocks = 0;
                continue;
            end
            if (kc_start) kc_wait = $urandom_range(1, 4);
            else if (kc_wait > 0) begin
                kc_wait--;
                if (kc_wait == 0) kc_done = 1'b1;
            end
            if (blk_valid) begin
                if (!in_offer) begin
                    in_offer = 1'b1;
                    early    = $urandom_range(0, 1) == 1;
                    stall    = (resp_ent == stall_entry && resp_blocks == 0) ? 10 : $urandom_range(0, 3);
                end
                if (stall > 0) begin
                    stall--;
                    blk_ready = 1'b0;
                end else begin
                    blk_ready = 1'b1;
                    if (early) send_pulse();
                end
            end else begin
                blk_ready = 1'b0;
                if (in_offer) begin
                    in_offer = 1'b0;
                    if (!early) send_pulse();
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every launch, checks transfers and done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) check("valid_held", blk_valid, 1);
            prev_stall = blk_valid && !blk_ready;
            if (kc_start) begin
                launches++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL launch_extra actual=(%0d,%0d) required=none", i_idx, j_idx);
                end else begin
                    last_l = exp_q.pop_front();
                    check("launch", {i_idx, j_idx, kc_init, sqz_cnt, busy},
                          {last_l.i, last_l.j, last_l.init, last_l.cnt, 1'b1});
                    $display("launch i=%0d j=%0d init=%0d sqz=%0d", i_idx, j_idx, kc_init, sqz_cnt);
                end
            end
            if (blk_valid && blk_ready)
                check("xfer", {i_idx, j_idx, sqz_cnt}, {last_l.i, last_l.j, last_l.cnt + 4'd1});
            if (done) begin
                done_seen++;
                check("done_busy", busy, 0);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input logic exp_err, input bit spurious);
        int  d0;
        bit  ok;
        load_expect();
        resp_ent = 0; resp_blocks = 0;
        d0 = done_seen;
        pulse_start();
        if (spurious) begin
            repeat (3) @(negedge clk);
            check({tag, "_busy_mid"}, busy, 1);
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done_seen != d0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_done required=done", tag);
        end
        check({tag, "_err_sticky"}, err, exp_err);
        repeat (5) @(negedge clk);
        check({tag, "_done_cnt"}, done_seen - d0, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy"}, busy, 0);
        $display("pass %s done launches=%0d", tag, launches);
    endtask

    initial begin
        int  d0;
        bit  ok;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, i_idx, j_idx, kc_start, kc_init, blk_valid, sqz_cnt, err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All entries finish on their first block.
        for (int e = 0; e < N; e++) extra[e] = 0;
        run_pass("single", 1'b0, 1'b0);

        // Random extra squeezes; entry (1,2) needs two more blocks and stalls 10 cycles.
        for (int e = 0; e < N; e++) extra[e] = $urandom_range(0, 2);
        extra[6] = 2;
        stall_entry = 6;
        run_pass("multi", 1'b0, 1'b1);
        stall_entry = -1;

        // Reset while waiting on the core at entry (2,1).
        for (int e = 0; e < N; e++) extra[e] = 0;
        load_expect();
        resp_ent = 0; resp_blocks = 0;
        d0 = done_seen;
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (kc_start && i_idx == 8'd2 && j_idx == 8'd1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL abort_reach actual=not_reached required=entry_2_1");
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, i_idx, j_idx, kc_start, kc_init, blk_valid, sqz_cnt, err}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        $display("pass abort done launches=%0d", launches);
        run_pass("restart", 1'b0, 1'b0);

        // fin and more together on entry (2,1): advance and flag err.
        for (int e = 0; e < N; e++) extra[e] = $urandom_range(0, 1);
        both_entry = 9;
        run_pass("both", 1'b1, 1'b0);
        both_entry = -1;

        // A fresh start clears the sticky error.
        for (int e = 0; e < N; e++) extra[e] = 0;
        run_pass("clear", 1'b0, 1'b0);

`ifdef SHAKE_SQZ_LIMIT_EN
        all_more = 1'b1;
        run_pass("limit", 1'b1, 1'b0);
        all_more = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
